mod_counter_cascade: RTL

//   Parametrised, synchronous, multi-digit modulo counter (default: 2-digit BCD, 00..99).

---
 rtl/mod_counter_cascade.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mod_counter_cascade.sv
// Multi-digit modulo counter with up/down count, checked parallel load and enp/ent cascade.
// Optional build macro COUNTER_SAT_EN: counting holds at the terminal state instead of wrapping.
module mod_counter_cascade #(
    parameter int DIGITS  = 2,
    parameter int MODULUS = 10,
    parameter int DW      = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 ldn,
    input  logic                 enp,
    input  logic                 ent,
    input  logic                 up,
    input  logic [DIGITS*DW-1:0] data_in,
    output logic [DIGITS*DW-1:0] q_out,
    output logic                 rco,
    output logic                 load_err
);

    localparam int              QW        = DIGITS * DW;
    localparam logic [DW-1:0]   DIGIT_MAX = DW'(MODULUS - 1);
    localparam logic [DW:0]     DIGIT_MOD = (DW + 1)'(MODULUS);
    localparam logic [DW-1:0]   DIGIT_ONE = DW'(1);

    logic [QW-1:0] q_r;
    logic          load_err_r;
    logic [QW-1:0] next_q_s;
    logic [QW-1:0] count_q_s;
    logic [QW-1:0] load_q_s;
    logic          load_bad_s;
    logic [QW-1:0] ts_s;
    logic          at_ts_s;

    // Widened compare so MODULUS == 2**DW does not overflow the digit width.
    function automatic logic digit_ok(input logic [DW-1:0] d);
        return ({1'b0, d} < DIGIT_MOD);
    endfunction

    // Ripple carry/borrow through all digits within one cycle.
    always_comb begin : count_chain
        logic          c;
        logic [DW-1:0] d;
        next_q_s = q_r;
        c        = 1'b1;
        d        = '0;
        for (int i = 0; i < DIGITS; i++) begin
            d = q_r[i*DW +: DW];
            if (c) begin
                if (up) begin
                    if (d == DIGIT_MAX) begin
                        next_q_s[i*DW +: DW] = '0;
                        c = 1'b1;
                    end else begin
                        next_q_s[i*DW +: DW] = d + DIGIT_ONE;
                        c = 1'b0;
                    end
                end else begin
                    if (d == '0) begin
                        next_q_s[i*DW +: DW] = DIGIT_MAX;
                        c = 1'b1;
                    end else begin
                        next_q_s[i*DW +: DW] = d - DIGIT_ONE;
                        c = 1'b0;
                    end
                end
            end else begin
                next_q_s[i*DW +: DW] = d;
            end
        end
    end

    // Per-digit range check of the load value; bad digits load as zero.
    always_comb begin
        load_q_s   = '0;
        load_bad_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_ok(data_in[i*DW +: DW])) begin
                load_q_s[i*DW +: DW] = data_in[i*DW +: DW];
            end else begin
                load_q_s[i*DW +: DW] = '0;
                load_bad_s = 1'b1;
            end
        end
    end

    // Terminal state depends on direction; rco follows up and ent without a clock.
    always_comb begin
        ts_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (up) begin
                ts_s[i*DW +: DW] = DIGIT_MAX;
            end else begin
                ts_s[i*DW +: DW] = '0;
            end
        end
        at_ts_s = (q_r == ts_s);
    end

    // Select wrap or saturate behaviour at the terminal state.
    always_comb begin
`ifdef COUNTER_SAT_EN
        if (at_ts_s) begin
            count_q_s = q_r;
        end else begin
            count_q_s = next_q_s;
        end
`else
        count_q_s = next_q_s;
`endif
    end

    // State register: clear beats load beats count beats hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            q_r        <= '0;
            load_err_r <= 1'b0;
        end else if (!ldn) begin
            q_r        <= load_q_s;
            load_err_r <= load_bad_s;
        end else if (enp && ent) begin
            q_r        <= count_q_s;
            load_err_r <= load_err_r;
        end else begin
            q_r        <= q_r;
            load_err_r <= load_err_r;
        end
    end

    assign q_out    = q_r;
    assign load_err = load_err_r;
    assign rco      = ent & at_ts_s;

endmodule
